// File: rtl/crossdomain_event_sync_rx.sv
// crossdomain_event_sync_rx
// Multi-channel receiver for toggle-encoded events from foreign clock
// domains. Each channel is synchronised, edge-detected and counted in a
// saturating pending counter. Pending events leave one at a time through a
// single-register valid/ready slice with round-robin arbitration. A per-channel
// ack toggle is returned for every consumed event.
// Optional build macro: CROSSDOMAIN_EVT_OVF_EN enables the sticky per-channel
// overflow flags (ovf/ovf_clr); when undefined, ovf is tied low and events
// arriving at a saturated counter are dropped silently.
module crossdomain_event_sync_rx #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  toggle_in,
    output logic [NCH-1:0]  ack_toggle_out,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_chan,
    output logic [NCH-1:0]  ovf,
    input  logic [NCH-1:0]  ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);

    // Synchroniser chain, stage 0 faces the asynchronous inputs
    logic [NCH-1:0]   sync_q [SYNC_STAGES];
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   det;

    // Pending-event bookkeeping
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W:0]   step_res [NCH];
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   drop;

    // Arbitration
    logic [CH_W-1:0]  ptr_q;
    logic [CH_W-1:0]  sel;
    logic [CH_W-1:0]  cand;
    logic             found;
    int               arb_idx;
    logic [NCH-1:0]   grant;

    // Output slice and ack return
    logic             vld_q;
    logic [CH_W-1:0]  chan_q;
    logic             load_en;
    logic             take;
    logic             consume;
    logic [NCH-1:0]   ack_hit;
    logic [NCH-1:0]   ack_q;

    // Saturating up/down step. Result MSB flags an increment that found the
    // counter already full with no matching decrement (event lost); the
    // lower bits are the next count.
    function automatic logic [CNT_W:0] cnt_step(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W:0] res;
        res = {1'b0, cur};
        if (inc && !dec) begin
            if (cur == CNT_MAX) begin
                res = {1'b1, cur};
            end else begin
                res = {1'b0, cur + 1'b1};
            end
        end else if (dec && !inc) begin
            res = {1'b0, cur - 1'b1};
        end
        return res;
    endfunction

    // ---- stage: synchroniser shift registers and previous-value capture ----
    // Shift each toggle input through the synchroniser and remember the last stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= toggle_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign det = sync_q[SYNC_STAGES-1] ^ prev_q;

    // Flag channels holding at least one undelivered event
    always_comb begin
        pend = '0;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = (cnt_q[i] != '0);
        end
    end

    // Round-robin search starting at ptr_q, wrapping modulo NCH
    always_comb begin
        sel     = ptr_q;
        found   = 1'b0;
        arb_idx = 0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NCH) begin
                arb_idx = arb_idx - NCH;
            end
            cand = CH_W'(arb_idx);
            if (!found && pend[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    // The slice reloads when empty or when its current event is being consumed
    assign load_en = !vld_q || evt_ready;
    assign take    = load_en && found;
    assign consume = vld_q && evt_ready;

    // Decode the winning channel and the channel being acknowledged
    always_comb begin
        grant   = '0;
        ack_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            grant[i]   = take && (sel == CH_W'(i));
            ack_hit[i] = consume && (chan_q == CH_W'(i));
        end
    end

    // Next pending count and lost-event flag per channel
    always_comb begin
        drop = '0;
        for (int i = 0; i < NCH; i++) begin
            step_res[i] = cnt_step(cnt_q[i], det[i], grant[i]);
            drop[i]     = step_res[i][CNT_W];
        end
    end

    // ---- stage: pending counters ----
    // Count detected events up and granted events down, saturating at full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= step_res[i][CNT_W-1:0];
            end
        end
    end

    // ---- stage: output slice and round-robin pointer ----
    // Load the arbitration winner, or empty the slice when nothing is pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            chan_q <= '0;
            ptr_q  <= '0;
        end else if (take) begin
            vld_q  <= 1'b1;
            chan_q <= sel;
            ptr_q  <= (sel == LAST_CH) ? '0 : sel + 1'b1;
        end else if (load_en) begin
            vld_q  <= 1'b0;
        end
    end

    // Flip the ack toggle of the channel whose event is consumed this edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= '0;
        end else begin
            ack_q <= ack_q ^ ack_hit;
        end
    end

`ifdef CROSSDOMAIN_EVT_OVF_EN
    logic [NCH-1:0] ovf_q;

    // Sticky overflow: a lost event sets the flag, ovf_clr clears it, set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~ovf_clr) | drop;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;

    assign ovf        = '0;
    assign unused_ovf = ^{drop, ovf_clr};
`endif

    assign evt_valid      = vld_q;
    assign evt_chan       = chan_q;
    assign ack_toggle_out = ack_q;

endmodule

// File: tb/tb_crossdomain_event_sync_rx.sv
// Bench for crossdomain_event_sync_rx (NCH=4, SYNC_STAGES=2, CNT_W=3).
// A cycle-level reference model built from pending counts, a sampled-input
// history and a modulo round-robin pointer predicts every output each cycle.
module tb_crossdomain_event_sync_rx;

    localparam int NCH   = 4;
    localparam int SS    = 2;
    localparam int CNT_W = 3;
    localparam int CH_W  = 2;
    localparam int MAXP  = (1 << CNT_W) - 1;
`ifdef CROSSDOMAIN_EVT_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NCH-1:0]  toggle_in;
    logic [NCH-1:0]  ack_toggle_out;
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_chan;
    logic [NCH-1:0]  ovf;
    logic [NCH-1:0]  ovf_clr;

    always #5 clk = ~clk;

    crossdomain_event_sync_rx #(
        .NCH         (NCH),
        .SYNC_STAGES (SS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .toggle_in      (toggle_in),
        .ack_toggle_out (ack_toggle_out),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_chan       (evt_chan),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int             m_pend [NCH];
    bit             m_valid;
    int             m_chan;
    int             m_ptr;
    bit [NCH-1:0]   m_ack;
    bit [NCH-1:0]   m_ovf;
    logic [NCH-1:0] m_hist [SS+2];

    // Observation of consumed events
    int cons [NCH];
    int repeats;
    int last_chan;
    bit have_last;
    int hold [NCH];

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) m_pend[i] = 0;
        for (int k = 0; k < SS + 2; k++) m_hist[k] = '0;
        m_valid = 0;
        m_chan  = 0;
        m_ptr   = 0;
        m_ack   = '0;
        m_ovf   = '0;
    endtask

    // One active clock edge of the model, using inputs present at that edge
    task automatic m_edge();
        logic [NCH-1:0] det;
        bit [NCH-1:0]   gnt;
        bit             found;
        int             sel;
        int             c;
        bit             lost;
        for (int k = SS + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = toggle_in;
        det = m_hist[SS] ^ m_hist[SS+1];
        if (m_valid && evt_ready) m_ack[m_chan] = ~m_ack[m_chan];
        gnt   = '0;
        found = 0;
        sel   = 0;
        if (!m_valid || evt_ready) begin
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (!found && m_pend[c] > 0) begin
                    found = 1;
                    sel   = c;
                end
            end
            if (found) begin
                gnt[sel] = 1;
                m_valid  = 1;
                m_chan   = sel;
                m_ptr    = (sel + 1) % NCH;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            lost = det[i] && !gnt[i] && (m_pend[i] == MAXP);
            if (OVF_ON) m_ovf[i] = (m_ovf[i] && !ovf_clr[i]) || lost;
            m_pend[i] = m_pend[i] - int'(gnt[i]) + int'(det[i] && !lost);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_chan", 32'(evt_chan), 32'(m_chan));
        chk("ack_toggle_out", 32'(ack_toggle_out), 32'(m_ack));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NCH; i++) cons[i] = 0;
        repeats   = 0;
        last_chan = -1;
        have_last = 0;
    endtask

    // Called at a falling edge: note any consumption, advance one clock, check
    task automatic step();
        if (evt_valid && evt_ready) begin
            cons[int'(evt_chan)]++;
            if (have_last && last_chan == int'(evt_chan)) repeats++;
            last_chan = int'(evt_chan);
            have_last = 1;
        end
        @(posedge clk);
        if (!reset_n) m_reset();
        else m_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_step(input int rdy_pct);
        for (int i = 0; i < NCH; i++) begin
            if (hold[i] >= SS + 1 && $urandom_range(0, 3) == 0) begin
                toggle_in[i] = ~toggle_in[i];
                hold[i]      = 0;
            end
            hold[i]++;
        end
        evt_ready = ($urandom_range(0, 99) < rdy_pct);
        ovf_clr   = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        toggle_in = '0;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        m_reset();
        clear_obs();
        @(negedge clk);
        repeat (3) step();
        chk("reset_valid", 32'(evt_valid), 32'd0);
        chk("reset_ack", 32'(ack_toggle_out), 32'd0);

        // Single event on channel 2
        reset_n   = 1'b1;
        toggle_in = 4'b0100;
        evt_ready = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 3) chk("single_valid_e3", 32'(evt_valid), 32'd0);
            if (e == 4) begin
                chk("single_valid_e4", 32'(evt_valid), 32'd1);
                chk("single_chan_e4", 32'(evt_chan), 32'd2);
            end
            if (e == 5) begin
                chk("single_valid_e5", 32'(evt_valid), 32'd0);
                chk("single_ack_e5", 32'(ack_toggle_out), 32'b0100);
            end
        end

        // Simultaneous events on 0, 1 and 3 from a fresh reset
        reset_n   = 1'b0;
        toggle_in = '0;
        repeat (2) step();
        reset_n   = 1'b1;
        toggle_in = 4'b1011;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 4) chk("multi_chan_e4", 32'({evt_valid, evt_chan}), 32'({1'b1, 2'd0}));
            if (e == 5) chk("multi_chan_e5", 32'({evt_valid, evt_chan}), 32'({1'b1, 2'd1}));
            if (e == 6) chk("multi_chan_e6", 32'({evt_valid, evt_chan}), 32'({1'b1, 2'd3}));
            if (e == 7) chk("multi_valid_e7", 32'(evt_valid), 32'd0);
        end
        chk("multi_ack", 32'(ack_toggle_out), 32'b1011);

        // Reset asserted with events pending and one presented
        evt_ready = 1'b0;
        toggle_in = toggle_in ^ 4'b0101;
        repeat (6) step();
        chk("pre_reset_valid", 32'(evt_valid), 32'd1);
        reset_n   = 1'b0;
        toggle_in = '0;
        #1;
        m_reset();
        check_all();
        chk("midreset_valid", 32'(evt_valid), 32'd0);
        chk("midreset_ack", 32'(ack_toggle_out), 32'd0);
        @(negedge clk);
        repeat (2) step();
        reset_n   = 1'b1;
        evt_ready = 1'b1;
        clear_obs();
        repeat (10) step();
        chk("postreset_events", 32'(cons[0] + cons[1] + cons[2] + cons[3]), 32'd0);
        chk("postreset_ack", 32'(ack_toggle_out), 32'd0);

        // Backpressure and saturation on channel 1
        evt_ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            toggle_in[1] = ~toggle_in[1];
            repeat (4) step();
        end
        chk("bp_valid", 32'({evt_valid, evt_chan}), 32'({1'b1, 2'd1}));
        chk("bp_ovf1", 32'(ovf[1]), 32'(OVF_ON));
        clear_obs();
        evt_ready = 1'b1;
        repeat (12) step();
        chk("bp_drained", 32'(cons[1]), 32'd8);
        chk("bp_ack", 32'(ack_toggle_out), 32'b0000);
        ovf_clr = 4'b0010;
        step();
        ovf_clr = '0;
        chk("bp_ovf_clr", 32'(ovf[1]), 32'd0);

        // Fairness between channels 0 and 3
        evt_ready = 1'b0;
        for (int r = 0; r < 10; r++) begin
            toggle_in = toggle_in ^ 4'b1001;
            repeat (3) step();
        end
        clear_obs();
        evt_ready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            toggle_in = toggle_in ^ 4'b1001;
            repeat (3) step();
        end
        repeat (10) step();
        chk("fair_repeats", 32'(repeats), 32'd0);
        chk("fair_ch0_served", 32'(cons[0] >= 20), 32'd1);
        chk("fair_balance", 32'((cons[0] - cons[3] <= 1) && (cons[3] - cons[0] <= 1)), 32'd1);
        ovf_clr = 4'b1111;
        step();
        ovf_clr = '0;

        // Randomised traffic, light and heavy backpressure
        for (int i = 0; i < NCH; i++) hold[i] = 0;
        repeat (300) rand_step(75);
        repeat (200) rand_step(15);
        repeat (100) rand_step(90);

        // Stability: inputs held after the backlog drains
        evt_ready = 1'b1;
        ovf_clr   = '0;
        repeat (4) step();
        toggle_in = 4'b1111;
        repeat (40) step();
        for (int c = 0; c < 100; c++) begin
            step();
            chk("stable_valid", 32'(evt_valid), 32'd0);
        end
        clear_obs();
        toggle_in[2] = ~toggle_in[2];
        repeat (8) step();
        chk("stable_one_event", 32'(cons[2]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
